// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: FSM state encoding and the per-stage slot record.
package hazard_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BUBBLE = 2'd1,
      FREEZE = 2'd2
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regwrite;
      logic                  memread;
   } slot_t;

endpackage

// File: rtl/hazard_slot.sv
// One pipeline slot register: synchronous clear, otherwise loads unless held.
module hazard_slot
   import hazard_pkg::*;
(
   input  logic  clk,
   input  logic  clr,
   input  logic  hold,
   input  slot_t d,
   output slot_t q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations through EX/MEM/WB and raises load-use stalls,
// memory-wait freezes and deferred branch flushes for the ID stage.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_regwrite_i,
   input  logic                  id_memread_i,
   input  logic                  flush_i,
   input  logic                  mem_stall_i,
   output logic                  stall_o,
   output logic                  bubble_o,
   output logic                  flush_o,
   output logic                  mem_regwrite_o,
   output logic [REG_ADDR_W-1:0] mem_rd_o,
   output logic                  wb_regwrite_o,
   output logic [REG_ADDR_W-1:0] wb_rd_o,
   output logic [1:0]            state_o,
   output logic [CNT_W-1:0]      lu_cnt_o,
   output logic [CNT_W-1:0]      frz_cnt_o
);

   slot_t            ex_q, mem_q, wb_q, ex_d;
   state_t           state_q, state_d;
   logic             load_use, stall_raw;
   logic [CNT_W-1:0] lu_cnt_q, frz_cnt_q;

   hazard_slot u_ex  (.clk(clk_i), .clr(rst_i), .hold(mem_stall_i), .d(ex_d),  .q(ex_q));
   hazard_slot u_mem (.clk(clk_i), .clr(rst_i), .hold(mem_stall_i), .d(ex_q),  .q(mem_q));
   hazard_slot u_wb  (.clk(clk_i), .clr(rst_i), .hold(mem_stall_i), .d(mem_q), .q(wb_q));

   // Only a load still in EX is unresolvable; MEM/WB loads are forwarded.
   always_comb begin
      load_use = id_valid_i & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                 ((id_use_rs1_i & (id_rs1_i == ex_q.rd)) |
                  (id_use_rs2_i & (id_rs2_i == ex_q.rd)));
      stall_raw = mem_stall_i | load_use;
   end

   // A flushing branch still enters EX; flush_o only kills the IF/ID entry behind it.
   always_comb begin
      ex_d = '0;
      if (id_valid_i && !load_use) begin
         ex_d.valid    = 1'b1;
         ex_d.rd       = id_rd_i;
         ex_d.regwrite = id_regwrite_i;
         ex_d.memread  = id_memread_i;
      end
   end

   always_comb begin
      state_d = state_q;
      if (mem_stall_i) begin
         state_d = FREEZE;
      end else begin
         case (state_q)
            RUN:     state_d = load_use ? BUBBLE : RUN;
            BUBBLE:  state_d = RUN;
            FREEZE:  state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= RUN;
         lu_cnt_q  <= '0;
         frz_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == RUN) && load_use && !mem_stall_i && (lu_cnt_q != '1)) begin
            lu_cnt_q <= lu_cnt_q + 1'b1;
         end
         if ((state_q == FREEZE) && (frz_cnt_q != '1)) begin
            frz_cnt_q <= frz_cnt_q + 1'b1;
         end
      end
   end

   // Every output is forced low while reset is asserted, including the registered ones.
   always_comb begin
      stall_o        = !rst_i & stall_raw;
      bubble_o       = !rst_i & load_use & !mem_stall_i;
      flush_o        = !rst_i & flush_i & !stall_raw;
      mem_regwrite_o = !rst_i & mem_q.valid & mem_q.regwrite;
      mem_rd_o       = (!rst_i && mem_q.valid) ? mem_q.rd : '0;
      wb_regwrite_o  = !rst_i & wb_q.valid & wb_q.regwrite;
      wb_rd_o        = (!rst_i && wb_q.valid) ? wb_q.rd : '0;
      state_o        = rst_i ? 2'd0 : state_q;
      lu_cnt_o       = rst_i ? '0 : lu_cnt_q;
      frz_cnt_o      = rst_i ? '0 : frz_cnt_q;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic checked against a behavioural pipeline model.
module tb_hazard_scoreboard;

   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, id_valid, use1, use2, id_rw, id_mr, flush, mem_stall;
   logic [4:0]   rs1, rs2, id_rd;
   logic         stall_o, bubble_o, flush_o, mem_regwrite_o, wb_regwrite_o;
   logic [4:0]   mem_rd_o, wb_rd_o;
   logic [1:0]   state_o;
   logic [CW-1:0] lu_cnt_o, frz_cnt_o;

   int checks = 0;
   int failures = 0;

   hazard_scoreboard #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
      .id_use_rs1_i(use1), .id_use_rs2_i(use2), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
      .id_memread_i(id_mr), .flush_i(flush), .mem_stall_i(mem_stall),
      .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
      .mem_regwrite_o(mem_regwrite_o), .mem_rd_o(mem_rd_o),
      .wb_regwrite_o(wb_regwrite_o), .wb_rd_o(wb_rd_o), .state_o(state_o),
      .lu_cnt_o(lu_cnt_o), .frz_cnt_o(frz_cnt_o)
   );

   // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; state 0 RUN, 1 BUBBLE, 2 FREEZE.
   typedef struct { bit v; int rd; bit rw; bit mr; } mslot_t;
   mslot_t pipe[3];
   int mstate = 0, mlu = 0, mfrz = 0;

   function automatic bit m_hazard();
      int r = pipe[0].rd;
      return id_valid && pipe[0].v && pipe[0].mr && (r != 0) &&
             ((use1 && (int'(rs1) == r)) || (use2 && (int'(rs2) == r)));
   endfunction

   always @(posedge clk) begin
      bit h;
      h = m_hazard();
      if (rst) begin
         for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
         mstate = 0; mlu = 0; mfrz = 0;
      end else begin
         if (mstate == 0 && h && !mem_stall && mlu < SAT) mlu++;
         if (mstate == 2 && mfrz < SAT) mfrz++;
         mstate = mem_stall ? 2 : ((mstate == 0 && h) ? 1 : 0);
         if (!mem_stall) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (id_valid && !h) ? '{1, int'(id_rd), id_rw, id_mr} : '{0, 0, 0, 0};
         end
      end
   end

   function automatic logic [24:0] model_vec();
      bit h, st;
      if (rst) return '0;
      h  = m_hazard();
      st = mem_stall || h;
      return {st, h && !mem_stall, flush && !st,
              pipe[1].v && pipe[1].rw, pipe[1].v ? 5'(pipe[1].rd) : 5'd0,
              pipe[2].v && pipe[2].rw, pipe[2].v ? 5'(pipe[2].rd) : 5'd0,
              2'(mstate), CW'(mlu), CW'(mfrz)};
   endfunction

   function automatic logic [24:0] dut_vec();
      return {stall_o, bubble_o, flush_o, mem_regwrite_o, mem_rd_o,
              wb_regwrite_o, wb_rd_o, state_o, lu_cnt_o, frz_cnt_o};
   endfunction

   task automatic drive(input bit r, input bit v, input int s1, input int s2, input bit u1,
                        input bit u2, input int d, input bit rw, input bit mr,
                        input bit fl, input bit ms);
      @(negedge clk);
      rst = r; id_valid = v; rs1 = 5'(s1); rs2 = 5'(s2); use1 = u1; use2 = u2;
      id_rd = 5'(d); id_rw = rw; id_mr = mr; flush = fl; mem_stall = ms;
      #1;
   endtask

   task automatic idle(input bit r, input bit ms);
      drive(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, ms);
   endtask

   task automatic load_x5();
      drive(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
   endtask

   task automatic add_x5(input bit fl, input bit ms);
      drive(0, 1, 5, 7, 1, 1, 6, 1, 0, fl, ms);
   endtask

   task automatic test_reset();
      idle(1, 0);
      idle(1, 1);
      checks++;
      if (stall_o !== 1'b0) begin
         failures++; $display("FAIL reset_stall got=%0b want=0", stall_o);
      end
      idle(0, 0);
      checks++;
      if (dut_vec() !== 25'd0) begin
         failures++; $display("FAIL reset_outputs got=%h want=0", dut_vec());
      end
   endtask

   task automatic test_load_use();
      idle(1, 0);
      load_x5();
      add_x5(0, 0);
      checks++;
      if ({stall_o, bubble_o} !== 2'b11) begin
         failures++; $display("FAIL lu_stall_bubble got=%b want=11", {stall_o, bubble_o});
      end
      add_x5(0, 0);
      checks++;
      if ({stall_o, mem_rd_o, lu_cnt_o, state_o} !== {1'b0, 5'd5, CW'(1), 2'd1}) begin
         failures++;
         $display("FAIL lu_after stall=%0b mem_rd=%0d lu=%0d state=%0d want 0/5/1/1",
                  stall_o, mem_rd_o, lu_cnt_o, state_o);
      end
   endtask

   task automatic test_load_x0();
      idle(1, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      drive(0, 1, 0, 0, 1, 1, 6, 1, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b0) begin
         failures++; $display("FAIL x0_stall got=%0b want=0", stall_o);
      end
   endtask

   task automatic test_forward_gap();
      idle(1, 0);
      load_x5();
      drive(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      add_x5(0, 0);
      checks++;
      if ({stall_o, mem_regwrite_o, mem_rd_o} !== {1'b0, 1'b1, 5'd5}) begin
         failures++;
         $display("FAIL gap stall=%0b mem_rw=%0b mem_rd=%0d want 0/1/5",
                  stall_o, mem_regwrite_o, mem_rd_o);
      end
   endtask

   task automatic test_freeze();
      idle(1, 0);
      load_x5();
      for (int i = 0; i < 4; i++) begin
         add_x5(0, 1);
         checks++;
         if ({stall_o, bubble_o} !== 2'b10) begin
            failures++; $display("FAIL frz_cycle%0d got=%b want=10", i, {stall_o, bubble_o});
         end
         if (i == 2) begin
            checks++;
            if (state_o !== 2'd2) begin
               failures++; $display("FAIL frz_state got=%0d want=2", state_o);
            end
         end
      end
      add_x5(0, 0);
      checks++;
      if ({stall_o, bubble_o} !== 2'b11) begin
         failures++; $display("FAIL frz_bubble got=%b want=11", {stall_o, bubble_o});
      end
      add_x5(0, 0);
      checks++;
      if ({stall_o, state_o, frz_cnt_o} !== {1'b0, 2'd0, CW'(4)}) begin
         failures++;
         $display("FAIL frz_end stall=%0b state=%0d frz=%0d want 0/0/4",
                  stall_o, state_o, frz_cnt_o);
      end
   endtask

   task automatic test_flush_defer();
      idle(1, 0);
      load_x5();
      add_x5(1, 0);
      checks++;
      if ({stall_o, flush_o} !== 2'b10) begin
         failures++; $display("FAIL flush_held got=%b want=10", {stall_o, flush_o});
      end
      add_x5(1, 0);
      checks++;
      if (flush_o !== 1'b1) begin
         failures++; $display("FAIL flush_late got=%0b want=1", flush_o);
      end
   endtask

   task automatic test_reset_in_freeze();
      idle(1, 0);
      load_x5();
      add_x5(0, 1);
      add_x5(0, 1);
      drive(1, 1, 5, 7, 1, 1, 6, 1, 0, 1, 1);
      checks++;
      if ({stall_o, bubble_o, flush_o} !== 3'b000) begin
         failures++; $display("FAIL rstfrz_comb got=%b want=000", {stall_o, bubble_o, flush_o});
      end
      idle(0, 0);
      checks++;
      if (dut_vec() !== 25'd0) begin
         failures++; $display("FAIL rstfrz_after got=%h want=0", dut_vec());
      end
   endtask

   task automatic test_saturation();
      idle(1, 0);
      for (int i = 0; i < SAT + 6; i++) idle(0, 1);
      idle(0, 0);
      checks++;
      if (frz_cnt_o !== CW'(SAT)) begin
         failures++; $display("FAIL frz_sat got=%0d want=%0d", frz_cnt_o, SAT);
      end
   endtask

   task automatic test_random();
      logic [24:0] exp_v;
      idle(1, 0);
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 59) == 0, $urandom_range(0, 5) != 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 4) == 0);
         exp_v = model_vec();
         checks++;
         if (dut_vec() !== exp_v) begin
            failures++; $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), exp_v);
         end
      end
   endtask

   initial begin
      rst = 1'b1; id_valid = 0; rs1 = '0; rs2 = '0; use1 = 0; use2 = 0;
      id_rd = '0; id_rw = 0; id_mr = 0; flush = 0; mem_stall = 0;
      test_reset();
      test_load_use();
      test_load_x0();
      test_forward_gap();
      test_freeze();
      test_flush_defer();
      test_reset_in_freeze();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
